// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch driver.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CHECK
  } state_t;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b01;
  localparam logic [1:0] ERR_MISMATCH  = 2'b10;
  localparam logic [1:0] ERR_FORBIDDEN = 2'b11;

  // Two cycles to clear the synchronizer, one more to sample it.
  localparam logic [3:0] CHECK_CYC = 4'd3;

  // Classify the synchronized latch feedback against the value the command should have left.
  function automatic logic [1:0] readback_err(input logic q, input logic qbar, input logic expect_q);
    if (q == qbar) begin
      return ERR_FORBIDDEN;
    end else if (q != expect_q) begin
      return ERR_MISMATCH;
    end else begin
      return ERR_OK;
    end
  endfunction

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer for the asynchronous latch feedback.
module sync2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Double-register the feedback so downstream logic sees a settled level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences set/reset commands onto a gated SR latch with setup/pulse/hold timing
// and verifies the latch state through a synchronized readback.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_W   = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       set_req,
  input  logic       rst_req,
  output logic       s,
  output logic       r,
  output logic       en,
  input  logic       q_fb,
  input  logic       qbar_fb,
  output logic       done,
  output logic [1:0] err
);

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       s_n, r_n, en_n, done_n;
  logic [1:0] err_n;
  logic       cmd_set, cmd_set_n;
  logic       q_sync, qbar_sync;

  sync2 #(.WIDTH(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({q_fb, qbar_fb}),
    .q     ({q_sync, qbar_sync})
  );

  assign req_ready = (state == IDLE);

  // Register state, timer, command memory and all latch-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      s       <= 1'b0;
      r       <= 1'b0;
      en      <= 1'b0;
      done    <= 1'b0;
      err     <= ERR_OK;
      cmd_set <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      s       <= s_n;
      r       <= r_n;
      en      <= en_n;
      done    <= done_n;
      err     <= err_n;
      cmd_set <= cmd_set_n;
    end
  end

  // Next-state and next-output logic; s/r only ever load complementary command bits.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    s_n       = s;
    r_n       = r;
    en_n      = en;
    done_n    = 1'b0;
    err_n     = ERR_OK;
    cmd_set_n = cmd_set;
    case (state)
      IDLE: begin
        s_n  = 1'b0;
        r_n  = 1'b0;
        en_n = 1'b0;
        if (req_valid) begin
          if (set_req && rst_req) begin
            done_n = 1'b1;
            err_n  = ERR_ILLEGAL;
          end else if (!set_req && !rst_req) begin
            done_n = 1'b1;
          end else begin
            state_n   = SETUP;
            cnt_n     = SETUP_LD;
            s_n       = set_req;
            r_n       = rst_req;
            cmd_set_n = set_req;
          end
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_n = PULSE;
          cnt_n   = PULSE_LD;
          en_n    = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      PULSE: begin
        if (cnt == 4'd0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
          en_n    = 1'b0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_n = CHECK;
          cnt_n   = CHECK_CYC - 4'd1;
          s_n     = 1'b0;
          r_n     = 1'b0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      CHECK: begin
        if (cnt == 4'd0) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
          done_n  = 1'b1;
          err_n   = readback_err(q_sync, qbar_sync, cmd_set);
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
        s_n     = 1'b0;
        r_n     = 1'b0;
        en_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Clocked sequencer directly upstream of the gated SR latch.
- Accepts set/reset commands over a valid/ready handshake and drives the latch's s, r and en inputs with guaranteed setup, pulse and hold timing.
- Never presents s=r=1 to the latch.
- Reads back the latch's q/qbar through a synchronizer and reports completion and error status.

Parameters:
SETUP_CYC, 1, cycles s/r held stable before en rises (1..15)
PULSE_W, 2, cycles en held high (1..15)
HOLD_CYC, 1, cycles s/r held stable after en falls (1..15)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  command valid
req_ready  output  1  driver idle, command accepted on valid&ready edge
set_req  input  1  command bit: set latch
rst_req  input  1  command bit: reset latch
s  output  1  to latch s
r  output  1  to latch r
en  output  1  to latch en
q_fb  input  1  latch q, asynchronous to clk
qbar_fb  input  1  latch qbar, asynchronous to clk
done  output  1  one-cycle completion pulse
err  output  2  status, valid only while done=1: 00 ok, 01 illegal command, 10 readback mismatch, 11 forbidden (q_fb==qbar_fb)

Behaviour:
- Reset values: s=0, r=0, en=0, done=0, err=00, state=IDLE, req_ready=1, counter=0, synchronizer flops=0.
- Reset is effective immediately at any point, including mid-pulse; en drops with no glitch back to 1.
- req_ready = (state==IDLE). All other outputs are registered.
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK. A 4-bit down-counter times each state.
- Command accept occurs at the edge where req_valid&req_ready; set_req/rst_req are captured at that edge.
- {set,rst}=11: no latch activity. Next cycle: done=1, err=01, state stays IDLE.
- {set,rst}=00 (no-op): no latch activity. Next cycle: done=1, err=00.
- {set,rst}=10 or 01 (cycle numbering from the accept edge):
  - SETUP_CYC cycles: s/r driven to the command value, en=0.
  - PULSE_W cycles: en=1, s/r unchanged.
  - HOLD_CYC cycles: en=0, s/r unchanged.
  - CHECK, 3 cycles: s=r=0, en=0. The 2 cycles let the feedback pass the 2-flop synchronizer; the 3rd samples it.
  - Next cycle: IDLE, done=1, req_ready=1.
- Defaults timeline: s or r high in cycles 0-3, en high in cycles 1-2, done in cycle 7.
- Readback check at the CHECK sample:
  - Synchronized q==qbar gives err=11; this takes priority.
  - Otherwise q differing from the expected value (set expects 1, reset expects 0) gives err=10.
  - Otherwise err=00.
- err returns to 00 the cycle after done.
- Back-to-back: a command can be accepted in the same cycle done is high. With req_valid held high, the next command starts with no bubble beyond that IDLE cycle.
- Commands presented while req_ready=0 are ignored. req_valid is not required to be held.
- s and r are never both 1. en is high only in PULSE.

Decomposition:
- Package sr_drv_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, HOLD, CHECK);
  - err codes ERR_OK, ERR_ILLEGAL, ERR_MISMATCH, ERR_FORBIDDEN;
  - the CHECK_CYC=3 constant.
- Sub-module sync2: a 2-flop synchronizer with async active-low reset. Instantiate it once per feedback bit, or once as a 2-bit vector.

Test Plan:
- Reset: assert rst_n=0 mid-PULSE -> en, s and r go 0 immediately; req_ready=1; done=0; after release FSM is IDLE.
- Set: feedback from a behavioural latch, accept {1,0} at edge 0 -> s=1 in cycles 0-3, en=1 in cycles 1-2, done=1 with err=00 in cycle 7.
- Reset command with PULSE_W=4, SETUP_CYC=2: accept {0,1} -> r=1 for 7 cycles, en=1 in cycles 2-5, done with err=00 in cycle 10.
- Illegal command: {1,1} accepted -> s, r and en stay 0; done=1 with err=01 in cycle 0.
- Faults: q_fb tied 0, qbar_fb tied 1 on a set -> err=10. Both tied 1 -> err=11.
- Back-to-back: req_valid held high with set then reset -> second accept lands in the first command's done cycle, and s=r=1 never occurs (checked by assertion).
